tsc_seq_detect: RTL and testbench

- Parametrised serial sequence detector; next generation of the TSC single-bit controller.
- Samples serial input A once per clock when enabled and compares the last PAT_LEN bits against a compile-time pattern.
- Emits a one-cycle pulse on B for each match and keeps a saturating match counter.
- Overlapping or non-overlapping detection is selectable at run time; sits between a serial source and downstream control logic.

---
 rtl/tsc_seq_detect.sv | 69 ++++++
 tb/tb_tsc_seq_detect.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tsc_seq_detect.sv
// Serial sequence detector: shifts in A on enabled edges, pulses B when the last
// PAT_LEN bits equal PATTERN, and keeps a saturating match counter.
module tsc_seq_detect #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             en,
    input  logic             overlap,
    output logic             B,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_b;
    logic [CNT_W-1:0]   r_count;
    logic               r_sat;

    logic [PAT_LEN-1:0] w_next_hist;
    logic [FILL_W-1:0]  w_next_fill;
    logic               w_hit;

    always_comb begin
        w_next_hist = {r_hist[PAT_LEN-2:0], A};
        w_next_fill = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        // fill gate keeps a zero-padded partial history from matching
        w_hit       = (w_next_fill == FILL_FULL) && (w_next_hist == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_b     <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (en) begin
            r_b <= w_hit;
            if (w_hit && !overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_next_hist;
                r_fill <= w_next_fill;
            end
            if (w_hit && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
                if (r_count + CNT_W'(1) == CNT_MAX)
                    r_sat <= 1'b1;
            end
        end else begin
            r_b <= 1'b0;
        end
    end

    assign B           = r_b;
    assign match_count = r_count;
    assign count_sat   = r_sat;

endmodule

// File: tb/tb_tsc_seq_detect.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// random stimulus against a sample-log reference model, over three parameterisations.
module tb_tsc_seq_detect;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic A = 1'b0;
    logic en = 1'b0;
    logic overlap = 1'b0;

    logic       b0, b1, b2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic       sat0, sat1, sat2;

    always #5 clk = ~clk;

    tsc_seq_detect u_dut (
        .clk(clk), .reset(reset), .A(A), .en(en), .overlap(overlap),
        .B(b0), .match_count(cnt0), .count_sat(sat0)
    );

    tsc_seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .A(A), .en(en), .overlap(overlap),
        .B(b1), .match_count(cnt1), .count_sat(sat1)
    );

    tsc_seq_detect #(.PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_dut_zero (
        .clk(clk), .reset(reset), .A(A), .en(en), .overlap(overlap),
        .B(b2), .match_count(cnt2), .count_sat(sat2)
    );

    int errors = 0;
    int checks = 0;

    // reference model: log of bits sampled since reset; a window may only start
    // at or after start_idx (moved past a match when overlap=0)
    int pat[3]  = '{11, 11, 0};
    int cmax[3] = '{255, 3, 255};
    bit log_q[$];
    int start_idx[3];
    int m_cnt[3];
    int m_sat[3];
    int m_b[3];

    typedef struct {
        logic rst;
        logic en;
        logic a;
        logic ov;
        logic b;
        int   cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic a,
                                input logic ov, input logic b, input int c);
        vec_t v;
        v.rst = r; v.en = e; v.a = a; v.ov = ov; v.b = b; v.cnt = c;
        vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_update(input logic r, input logic e,
                                         input logic a, input logic ov);
        int  n;
        bit  hit;
        if (!r) begin
            log_q.delete();
            for (int k = 0; k < 3; k++) begin
                start_idx[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_b[k] = 0;
            end
        end else if (!e) begin
            for (int k = 0; k < 3; k++) m_b[k] = 0;
        end else begin
            log_q.push_back(a);
            n = log_q.size();
            for (int k = 0; k < 3; k++) begin
                hit = (n - start_idx[k] >= 4);
                if (hit)
                    for (int j = 0; j < 4; j++)
                        if (int'(log_q[n-4+j]) != ((pat[k] >> (3 - j)) & 1)) hit = 0;
                m_b[k] = hit;
                if (hit) begin
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                    if (m_cnt[k] == cmax[k]) m_sat[k] = 1;
                    if (!ov) start_idx[k] = n;
                end
            end
        end
    endfunction

    function automatic void check_models(input string tag);
        check({tag, " B0"},   int'(b0),   m_b[0]);
        check({tag, " cnt0"}, int'(cnt0), m_cnt[0]);
        check({tag, " sat0"}, int'(sat0), m_sat[0]);
        check({tag, " B1"},   int'(b1),   m_b[1]);
        check({tag, " cnt1"}, int'(cnt1), m_cnt[1]);
        check({tag, " sat1"}, int'(sat1), m_sat[1]);
        check({tag, " B2"},   int'(b2),   m_b[2]);
        check({tag, " cnt2"}, int'(cnt2), m_cnt[2]);
        check({tag, " sat2"}, int'(sat2), m_sat[2]);
    endfunction

    task automatic step(input logic r, input logic e, input logic a,
                        input logic ov, input string tag);
        @(negedge clk);
        reset = r; en = e; A = a; overlap = ov;
        @(posedge clk);
        #1;
        model_update(r, e, a, ov);
        check_models(tag);
    endtask

    initial begin
        // directed table: {reset, en, A, overlap, expected B, expected count}
        add(0,1,1,1, 0,0);
        add(1,1,1,1, 0,0); add(1,1,0,1, 0,0); add(1,1,1,1, 0,0); add(1,1,1,1, 1,1);
        add(1,1,0,1, 0,1); add(1,1,1,1, 0,1); add(1,1,1,1, 1,2);
        add(0,1,0,0, 0,0);
        add(1,1,1,0, 0,0); add(1,1,0,0, 0,0); add(1,1,1,0, 0,0); add(1,1,1,0, 1,1);
        add(1,1,0,0, 0,1); add(1,1,1,0, 0,1); add(1,1,1,0, 0,1);
        add(0,1,0,1, 0,0);
        add(1,1,1,1, 0,0); add(1,1,0,1, 0,0);
        add(1,0,1,1, 0,0); add(1,0,1,1, 0,0); add(1,0,1,1, 0,0);
        add(1,1,1,1, 0,0); add(1,1,1,1, 1,1);
        add(0,1,0,1, 0,0);
        add(1,1,1,1, 0,0); add(1,1,0,1, 0,0); add(1,1,1,1, 0,0);
        add(0,1,1,1, 0,0);
        add(1,1,1,1, 0,0); add(1,1,0,1, 0,0); add(1,1,1,1, 0,0); add(1,1,1,1, 1,1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].ov, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl B", i),   int'(b0),   int'(vecs[i].b));
            check($sformatf("vec%0d tbl cnt", i), int'(cnt0), vecs[i].cnt);
            check($sformatf("vec%0d tbl sat", i), int'(sat0), 0);
        end

        // saturation on the 2-bit counter, non-overlapping
        step(0, 1, 0, 0, "sat rst");
        for (int rep = 0; rep < 5; rep++) begin
            step(1, 1, 1, 0, "sat");
            step(1, 1, 0, 0, "sat");
            step(1, 1, 1, 0, "sat");
            step(1, 1, 1, 0, "sat");
            check($sformatf("sat%0d B", rep),   int'(b1),   1);
            check($sformatf("sat%0d cnt", rep), int'(cnt1), (rep < 2) ? rep + 1 : 3);
            check($sformatf("sat%0d flag", rep), int'(sat1), (rep >= 2) ? 1 : 0);
        end

        // all-zero pattern: no match until four zeros, then every cycle with overlap
        step(0, 1, 0, 1, "zero rst");
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 1, "zero");
            check($sformatf("zero%0d B", i),   int'(b2),   (i >= 3) ? 1 : 0);
            check($sformatf("zero%0d cnt", i), int'(cnt2), (i >= 3) ? i - 2 : 0);
        end

        // random stimulus against the model
        step(0, 1, 0, 0, "rnd rst");
        for (int i = 0; i < 600; i++) begin
            logic r, e, a, ov;
            r  = ($urandom_range(0, 59) != 0);
            e  = ($urandom_range(0, 4) != 0);
            a  = ($urandom_range(0, 9) < 6);
            ov = $urandom_range(0, 1);
            step(r, e, a, ov, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
